mem_access: RTL and testbench

//  MEM pipeline stage directly downstream of EX. Consumes EX/MEM register contents (ALU result,

---
 rtl/mem_access.sv | 161 ++++++++++++++++
 tb/tb_mem_access.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// rtl/mem_access.sv - MEM pipeline stage: req/ack data-memory access, load extension, MEM/WB register (optional MEM_ALIGN_CHECK_EN)
module mem_access #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_rst_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [4:0]        rd_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              memtoreg_i,
    input  logic              regwrite_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    input  logic              dmem_ack_i,
    output logic              stall_o,
    output logic              misalign_o,
    output logic [4:0]        wb_rd_o,
    output logic              wb_regwrite_o,
    output logic              wb_memtoreg_o,
    output logic [DATA_W-1:0] wb_alu_rslt_o,
    output logic [DATA_W-1:0] wb_rdata_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    state_t            state;
    logic              is_mem;
    logic              misaligned;
    logic              access;
    logic              is_load;
    logic [1:0]        lane;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic [DATA_W-1:0] load_ext;
    logic              misalign_q;

    assign is_mem  = memread_i | memwrite_i;
    // A store that also claims to be a load is treated as a store.
    assign is_load = memread_i & ~memwrite_i;
    assign lane    = alu_rst_i[1:0];

    // Alignment check: only half/word can be misaligned; the default build never flags.
    always_comb begin
        misaligned = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        case (size_i)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = alu_rst_i[0];
            default: misaligned = (alu_rst_i[1:0] != 2'b00);
        endcase
`endif
    end

    assign access = is_mem & ~misaligned;

    // Request stays up for the whole transaction; reset kills it immediately.
    assign dmem_req_o = ~rst & (access | (state == ST_WAIT));
    assign stall_o    = ~rst & access & ~dmem_ack_i;
    assign dmem_we_o  = memwrite_i;
    assign dmem_addr_o = {alu_rst_i[ADDR_W-1:2], 2'b00};

    // Byte enables; half and word ignore the low address bits below their alignment.
    always_comb begin
        dmem_be_o = 4'b1111;
        case (size_i)
            SZ_BYTE: dmem_be_o = 4'b0001 << lane;
            SZ_HALF: dmem_be_o = lane[1] ? 4'b1100 : 4'b0011;
            default: dmem_be_o = 4'b1111;
        endcase
    end

    // Store data replicated across every lane so memory can pick by byte enable.
    always_comb begin
        dmem_wdata_o = mem_wdata_i;
        case (size_i)
            SZ_BYTE: dmem_wdata_o = {4{mem_wdata_i[7:0]}};
            SZ_HALF: dmem_wdata_o = {2{mem_wdata_i[15:0]}};
            default: dmem_wdata_o = mem_wdata_i;
        endcase
    end

    // Lane selection of the returned word for sub-word loads.
    always_comb begin
        load_byte = dmem_rdata_i[7:0];
        case (lane)
            2'd0: load_byte = dmem_rdata_i[7:0];
            2'd1: load_byte = dmem_rdata_i[15:8];
            2'd2: load_byte = dmem_rdata_i[23:16];
            default: load_byte = dmem_rdata_i[31:24];
        endcase
        load_half = lane[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    end

    // Sign or zero extension of the selected lane to full width.
    always_comb begin
        load_ext = dmem_rdata_i;
        case (size_i)
            SZ_BYTE: load_ext = unsigned_i ? {24'h0, load_byte}
                                           : {{24{load_byte[7]}}, load_byte};
            SZ_HALF: load_ext = unsigned_i ? {16'h0, load_half}
                                           : {{16{load_half[15]}}, load_half};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    // Transaction FSM: IDLE completes zero-wait accesses, WAIT holds until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (access && !dmem_ack_i) state <= ST_WAIT;
                ST_WAIT: if (dmem_ack_i || !access) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // MEM/WB register: advance when not stalled, insert a bubble while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_rd_o       <= 5'd0;
            wb_regwrite_o <= 1'b0;
            wb_memtoreg_o <= 1'b0;
            wb_alu_rslt_o <= '0;
            wb_rdata_o    <= '0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= is_mem & misaligned;
            if (stall_o) begin
                wb_regwrite_o <= 1'b0;
            end else begin
                wb_rd_o       <= rd_i;
                wb_regwrite_o <= regwrite_i & ~(is_mem & misaligned);
                wb_memtoreg_o <= memtoreg_i;
                wb_alu_rslt_o <= alu_rst_i;
                wb_rdata_o    <= (is_load && access && dmem_ack_i) ? load_ext : '0;
            end
        end
    end

    assign misalign_o = misalign_q;
    assign fwd_data_o = wb_memtoreg_o ? wb_rdata_o : wb_alu_rslt_o;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access with a MEM/WB scoreboard
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic [31:0] alu_rst_i;
    logic [31:0] mem_wdata_i;
    logic [4:0]  rd_i;
    logic        memread_i;
    logic        memwrite_i;
    logic        memtoreg_i;
    logic        regwrite_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;
    logic        stall_o;
    logic        misalign_o;
    logic [4:0]  wb_rd_o;
    logic        wb_regwrite_o;
    logic        wb_memtoreg_o;
    logic [31:0] wb_alu_rslt_o;
    logic [31:0] wb_rdata_o;
    logic [31:0] fwd_data_o;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        mtr;
        logic [31:0] alu;
        logic [31:0] rdata;
    } wb_t;

    wb_t sb[$];
    int  checks;
    int  failures;

    mem_access dut (
        .clk(clk), .rst(rst),
        .alu_rst_i(alu_rst_i), .mem_wdata_i(mem_wdata_i), .rd_i(rd_i),
        .memread_i(memread_i), .memwrite_i(memwrite_i), .memtoreg_i(memtoreg_i),
        .regwrite_i(regwrite_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_rdata_i(dmem_rdata_i),
        .dmem_ack_i(dmem_ack_i), .stall_o(stall_o), .misalign_o(misalign_o),
        .wb_rd_o(wb_rd_o), .wb_regwrite_o(wb_regwrite_o), .wb_memtoreg_o(wb_memtoreg_o),
        .wb_alu_rslt_o(wb_alu_rslt_o), .wb_rdata_o(wb_rdata_o), .fwd_data_o(fwd_data_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
        if (sz == 2'b00) return 4'b0001 << a;
        if (sz == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdat, input logic [1:0] sz,
                                               input logic [1:0] a, input logic uns);
        logic [31:0] sh;
        if (sz == 2'b00) begin
            sh = rdat >> (8 * a);
            return uns ? (sh & 32'hFF) : {{24{sh[7]}}, sh[7:0]};
        end
        if (sz == 2'b01) begin
            sh = rdat >> (a[1] ? 16 : 0);
            return uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
        end
        return rdat;
    endfunction

    task automatic clear_inputs();
        alu_rst_i = 32'h0; mem_wdata_i = 32'h0; rd_i = 5'd0;
        memread_i = 1'b0; memwrite_i = 1'b0; memtoreg_i = 1'b0; regwrite_i = 1'b0;
        size_i = 2'b10; unsigned_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
    endtask

    // Drives one op, models the memory ack delay, then pops and checks the MEM/WB result.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic mtr, input logic rw,
                          input logic [1:0] sz, input logic uns, input logic [31:0] rdat,
                          input int delay, input logic exp_req, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                          input logic exp_rw);
        wb_t e;
        wb_t got;
        logic [31:0] exp_fwd;
        got = '{rd, exp_rw, mtr, alu, exp_rdata};
        sb.push_back(got);
        @(posedge clk); #1;
        alu_rst_i = alu; mem_wdata_i = wd; rd_i = rd; memread_i = mr; memwrite_i = mw;
        memtoreg_i = mtr; regwrite_i = rw; size_i = sz; unsigned_i = uns; dmem_rdata_i = rdat;
        dmem_ack_i = exp_req && (delay == 0);
        for (int c = 0; c <= delay; c++) begin
            @(negedge clk);
            checks++;
            if (dmem_req_o !== exp_req) begin
                failures++; $display("FAIL req c=%0d: got %b want %b", c, dmem_req_o, exp_req);
            end
            checks++;
            if (stall_o !== (exp_req && c < delay)) begin
                failures++; $display("FAIL stall c=%0d: got %b want %b", c, stall_o, exp_req && c < delay);
            end
            if (c == 0 && exp_req) begin
                checks++;
                if (dmem_be_o !== exp_be) begin
                    failures++; $display("FAIL be: got %b want %b", dmem_be_o, exp_be);
                end
                checks++;
                if (dmem_we_o !== mw || dmem_addr_o !== {alu[31:2], 2'b00}) begin
                    failures++; $display("FAIL we_addr: got %b/%h want %b/%h", dmem_we_o, dmem_addr_o, mw, {alu[31:2], 2'b00});
                end
                if (mw) begin
                    checks++;
                    if (dmem_wdata_o !== exp_wdata) begin
                        failures++; $display("FAIL wdata: got %h want %h", dmem_wdata_o, exp_wdata);
                    end
                end
            end
            if (c > 0) begin
                checks++;
                if (wb_regwrite_o !== 1'b0) begin
                    failures++; $display("FAIL bubble c=%0d: got regwrite %b want 0", c, wb_regwrite_o);
                end
            end
            @(posedge clk); #1;
            if (exp_req && (c + 1 == delay)) dmem_ack_i = 1'b1;
        end
        clear_inputs();
        @(negedge clk);
        e = sb.pop_front();
        exp_fwd = e.mtr ? e.rdata : e.alu;
        checks++;
        if (wb_rd_o !== e.rd || wb_regwrite_o !== e.rw || wb_memtoreg_o !== e.mtr) begin
            failures++; $display("FAIL wb_ctrl: got rd=%0d rw=%b mtr=%b want rd=%0d rw=%b mtr=%b",
                                 wb_rd_o, wb_regwrite_o, wb_memtoreg_o, e.rd, e.rw, e.mtr);
        end
        checks++;
        if (wb_alu_rslt_o !== e.alu || wb_rdata_o !== e.rdata) begin
            failures++; $display("FAIL wb_data: got alu=%h rdata=%h want alu=%h rdata=%h",
                                 wb_alu_rslt_o, wb_rdata_o, e.alu, e.rdata);
        end
        checks++;
        if (fwd_data_o !== exp_fwd || misalign_o !== 1'b0) begin
            failures++; $display("FAIL fwd: got %h mis=%b want %h mis=0", fwd_data_o, misalign_o, exp_fwd);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        memread_i = 1'b1; regwrite_i = 1'b1; rd_i = 5'd3; alu_rst_i = 32'h40;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL reset_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_o);
        end
        checks++;
        if (wb_rd_o !== 5'd0 || wb_regwrite_o !== 1'b0 || wb_memtoreg_o !== 1'b0 ||
            wb_alu_rslt_o !== 32'h0 || wb_rdata_o !== 32'h0 || misalign_o !== 1'b0) begin
            failures++; $display("FAIL reset_wb: got rd=%0d rw=%b alu=%h rdata=%h mis=%b want all 0",
                                 wb_rd_o, wb_regwrite_o, wb_alu_rslt_o, wb_rdata_o, misalign_o);
        end
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_alu_pass();
        run_op(32'h1234, 32'h0, 5'd5, 0, 0, 0, 1, 2'b10, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    endtask

    task automatic test_store_zero_wait();
        run_op(32'h100, 32'hAABBCCDD, 5'd0, 0, 1, 0, 0, 2'b10, 0, 32'h0, 0, 1, 4'b1111,
               32'hAABBCCDD, 32'h0, 0);
        run_op(32'h102, 32'h000000EE, 5'd0, 0, 1, 0, 0, 2'b00, 0, 32'h0, 1, 1, 4'b0100,
               32'hEEEEEEEE, 32'h0, 0);
    endtask

    task automatic test_load_byte_wait();
        run_op(32'h103, 32'h0, 5'd9, 1, 0, 1, 1, 2'b00, 0, 32'h80FFFFFF, 3, 1, 4'b1000,
               32'h0, 32'hFFFFFF80, 1);
    endtask

    task automatic test_load_half_unsigned();
        run_op(32'h102, 32'h0, 5'd10, 1, 0, 1, 1, 2'b01, 1, 32'h9ABC0000, 1, 1, 4'b1100,
               32'h0, 32'h00009ABC, 1);
    endtask

    task automatic test_spurious_ack();
        @(posedge clk); #1;
        rd_i = 5'd7; regwrite_i = 1'b1; alu_rst_i = 32'h55; dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hDEADBEEF;
        @(negedge clk);
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL spurious_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_o);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (wb_rd_o !== 5'd7 || wb_regwrite_o !== 1'b1 || wb_rdata_o !== 32'h0 || fwd_data_o !== 32'h55) begin
            failures++; $display("FAIL spurious_wb: got rd=%0d rw=%b rdata=%h fwd=%h want 7/1/0/55",
                                 wb_rd_o, wb_regwrite_o, wb_rdata_o, fwd_data_o);
        end
    endtask

    task automatic test_reset_mid_wait();
        run_op(32'h777, 32'h0, 5'd12, 0, 0, 0, 1, 2'b10, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
        @(posedge clk); #1;
        alu_rst_i = 32'h300; rd_i = 5'd13; memread_i = 1'b1; memtoreg_i = 1'b1;
        regwrite_i = 1'b1; size_i = 2'b10;
        @(posedge clk); #1;
        checks++;
        if (stall_o !== 1'b1 || dmem_req_o !== 1'b1) begin
            failures++; $display("FAIL wait_entry: got req=%b stall=%b want 1/1", dmem_req_o, stall_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL rst_wait_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_o);
        end
        checks++;
        if (wb_rd_o !== 5'd0 || wb_regwrite_o !== 1'b0 || wb_alu_rslt_o !== 32'h0 || fwd_data_o !== 32'h0) begin
            failures++; $display("FAIL rst_wait_wb: got rd=%0d rw=%b alu=%h fwd=%h want all 0",
                                 wb_rd_o, wb_regwrite_o, wb_alu_rslt_o, fwd_data_o);
        end
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b0;
        run_op(32'h304, 32'h0, 5'd14, 1, 0, 1, 1, 2'b10, 0, 32'hCAFEF00D, 1, 1, 4'b1111,
               32'h0, 32'hCAFEF00D, 1);
    endtask

    task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
        @(posedge clk); #1;
        alu_rst_i = 32'h101; rd_i = 5'd6; memread_i = 1'b1; memtoreg_i = 1'b1;
        regwrite_i = 1'b1; size_i = 2'b10; dmem_ack_i = 1'b0;
        @(negedge clk);
        checks++;
        if (dmem_req_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL mis_req: got req=%b stall=%b want 0/0", dmem_req_o, stall_o);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (misalign_o !== 1'b1 || wb_regwrite_o !== 1'b0) begin
            failures++; $display("FAIL mis_flag: got mis=%b rw=%b want 1/0", misalign_o, wb_regwrite_o);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (misalign_o !== 1'b0) begin
            failures++; $display("FAIL mis_pulse: got %b want 0", misalign_o);
        end
`else
        run_op(32'h101, 32'h0, 5'd6, 1, 0, 1, 1, 2'b10, 0, 32'h12345678, 0, 1, 4'b1111,
               32'h0, 32'h12345678, 1);
        run_op(32'h103, 32'h0, 5'd8, 1, 0, 1, 1, 2'b01, 0, 32'h80010000, 2, 1, 4'b1100,
               32'h0, 32'hFFFF8001, 1);
`endif
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            int          kind;
            int          dly;
            logic [1:0]  sz;
            logic [1:0]  lo;
            logic        uns;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [31:0] rdat;
            logic [4:0]  rd;
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            uns  = 1'($urandom_range(0, 1));
            lo   = (sz == 2'b00) ? 2'($urandom_range(0, 3)) : (sz == 2'b01) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            addr = 32'h200 + 32'(i * 16) + {30'h0, lo};
            wd   = $urandom;
            rdat = $urandom;
            rd   = 5'($urandom_range(1, 31));
            dly  = $urandom_range(0, 2);
            if (kind == 0)
                run_op(addr, wd, rd, 0, 0, 0, 1, sz, uns, rdat, 0, 0, 4'h0, 32'h0, 32'h0, 1);
            else if (kind == 1)
                run_op(addr, wd, rd, 1, 0, 1, 1, sz, uns, rdat, dly, 1, model_be(sz, lo),
                       32'h0, model_load(rdat, sz, lo, uns), 1);
            else
                run_op(addr, wd, rd, 0, 1, 0, 0, sz, uns, rdat, dly, 1, model_be(sz, lo),
                       model_wdata(sz, wd), 32'h0, 0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_alu_pass();
        test_store_zero_wait();
        test_load_byte_wait();
        test_load_half_unsigned();
        test_spurious_ack();
        test_reset_mid_wait();
        test_misalign();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
